// File: rtl/key_entry_ctrl_if.sv
// Keypad-side and result-side signals of the calculator entry controller.
// The master modport drives keys and observes results; slave is the controller.
interface key_entry_ctrl_if;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [9:0]  operand_a;
    logic [9:0]  operand_b;
    logic [10:0] result;
    logic [10:0] disp_value;
    logic [1:0]  state_out;
    logic        result_valid;
    logic [1:0]  digit_count;

    modport master (
        output key_code, key_pulse,
        input  operand_a, operand_b, result, disp_value, state_out, result_valid, digit_count
    );

    modport slave (
        input  key_code, key_pulse,
        output operand_a, operand_b, result, disp_value, state_out, result_valid, digit_count
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Two-operand decimal keypad entry and adder; key effects visible one cycle later, sum pulses 2 cycles after final ENTER.
// No backpressure: keys arriving during the single CALC cycle are dropped.
module key_entry_ctrl #(
    parameter int MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    key_entry_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_CALC    = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    state_t      state_q, state_d;
    logic [9:0]  op_a_q, op_a_d;
    logic [9:0]  op_b_q, op_b_d;
    logic [10:0] result_q, result_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rv_q, rv_d;

    logic        key_digit;
    logic        key_enter;
    logic        key_clear;
    logic [13:0] op_sel_ext;
    logic [9:0]  op_next;

    assign key_digit = (bus.key_code <= 4'd9);
    assign key_enter = (bus.key_code == 4'hA);
    assign key_clear = (bus.key_code == 4'hC);

    // Shift-and-add is done wide so a larger MAX_DIGITS cannot wrap mid-computation.
    assign op_sel_ext = (state_q == ST_ENTER_B) ? {4'd0, op_b_q} : {4'd0, op_a_q};
    assign op_next    = 10'(op_sel_ext * 14'd10 + {10'd0, bus.key_code});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ENTER_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            rv_q     <= rv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        rv_d     = 1'b0;

        if (state_q == ST_CALC) begin
            result_d = {1'b0, op_a_q} + {1'b0, op_b_q};
            rv_d     = 1'b1;
            state_d  = ST_SHOW;
        end else if (bus.key_pulse) begin
            if (key_clear) begin
                op_a_d   = '0;
                op_b_d   = '0;
                result_d = '0;
                cnt_d    = '0;
                state_d  = ST_ENTER_A;
            end else if (key_digit) begin
                if (state_q == ST_SHOW) begin
                    op_a_d  = {6'd0, bus.key_code};
                    op_b_d  = '0;
                    cnt_d   = 2'd1;
                    state_d = ST_ENTER_A;
                end else if (cnt_q < MAX_CNT) begin
                    if (state_q == ST_ENTER_A) begin
                        op_a_d = op_next;
                    end else begin
                        op_b_d = op_next;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
            end else if (key_enter && (state_q != ST_SHOW) && (cnt_q != 2'd0)) begin
                cnt_d = '0;
                if (state_q == ST_ENTER_A) begin
                    op_b_d  = '0;
                    state_d = ST_ENTER_B;
                end else begin
                    state_d = ST_CALC;
                end
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_ENTER_A: bus.disp_value = {1'b0, op_a_q};
            ST_ENTER_B: bus.disp_value = {1'b0, op_b_q};
            default:    bus.disp_value = result_q;
        endcase
    end

    assign bus.operand_a    = op_a_q;
    assign bus.operand_b    = op_b_q;
    assign bus.result       = result_q;
    assign bus.state_out    = state_q;
    assign bus.result_valid = rv_q;
    assign bus.digit_count  = cnt_q;

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_DIGITS, default 3, the maximum decimal digits accepted per operand.
REQ-002 The module SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port key_code  input  4  decoded key value: 0x0-0x9 digit, 0xA ENTER, 0xC CLEAR, all others ignored.
REQ-005 The module SHALL have port key_pulse  input  1  one-cycle strobe marking a new debounced key; key_code is sampled only when key_pulse=1.
REQ-006 The module SHALL have port operand_a  output  10  binary value of operand A (0-999).
REQ-007 The module SHALL have port operand_b  output  10  binary value of operand B (0-999).
REQ-008 The module SHALL have port result  output  11  registered sum A+B (0-1998).
REQ-009 The module SHALL have port disp_value  output  11  value to display: operand_a in ENTER_A, operand_b in ENTER_B, result in CALC/SHOW.
REQ-010 The module SHALL have port state_out  output  2  current state: 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW.
REQ-011 The module SHALL have port result_valid  output  1  one-cycle pulse when result is updated.
REQ-012 The module SHALL have port digit_count  output  2  digits accepted so far in the operand being entered.

Function
REQ-013 The FSM SHALL have states ENTER_A, ENTER_B, CALC and SHOW, and SHALL act only on cycles where key_pulse=1, except for CALC.
REQ-014 In ENTER_A/ENTER_B, a digit key with digit_count<MAX_DIGITS SHALL update the active operand to operand*10+digit and increment digit_count, with the new value visible the next cycle.
REQ-015 A digit key with digit_count=MAX_DIGITS SHALL be ignored; the operand and count are unchanged (e.g. 1,2,3,4 gives 123).
REQ-016 ENTER with digit_count=0 SHALL be ignored.
REQ-017 ENTER in ENTER_A with digit_count>0 SHALL move to ENTER_B, clear digit_count, and clear operand_b.
REQ-018 ENTER in ENTER_B with digit_count>0 SHALL move to CALC, clearing digit_count.
REQ-019 CALC SHALL last exactly one cycle: result <= operand_a + operand_b, zero-extended to 11 bits with no overflow possible, and the next state SHALL be SHOW.
REQ-020 result_valid SHALL be 1 during exactly the first SHOW cycle, i.e. 2 cycles after the ENTER pulse.
REQ-021 A key_pulse arriving while in CALC SHALL be ignored.
REQ-022 In SHOW, result and operands SHALL hold; ENTER and ignored codes SHALL have no effect.
REQ-023 In SHOW, a digit key SHALL clear both operands, load the digit into operand_a, set digit_count=1, and go to ENTER_A.
REQ-024 CLEAR in any state except CALC SHALL clear operand_a, operand_b, result and digit_count and go to ENTER_A, with result_valid=0.
REQ-025 Key codes 0xB, 0xD, 0xE and 0xF SHALL be ignored in every state.
REQ-026 Operand arithmetic SHALL use an internal width of at least 14 bits before truncation to 10 bits; truncation never occurs when MAX_DIGITS=3.

Reset
REQ-027 While rst_n=0, outputs SHALL be immediately forced to: state ENTER_A, operand_a=0, operand_b=0, result=0, digit_count=0, result_valid=0, disp_value=0.
REQ-028 Reset asserted mid-entry or during CALC SHALL abandon the operation; no result_valid pulse SHALL follow the release of reset.
REQ-029 After rst_n deasserts, the first key_pulse SHALL be processed normally in ENTER_A.

Verification
REQ-030 The bench SHALL cover: keys 1,2,ENTER,3,4,5,ENTER -> operand_a=12, operand_b=345, result=357, result_valid high for 1 cycle exactly 2 cycles after the second ENTER, disp_value=357.
REQ-031 The bench SHALL cover: keys 9,9,9,9,ENTER,9,9,9,ENTER -> operand_a=999 (4th digit ignored), result=1998.
REQ-032 The bench SHALL cover: ENTER in ENTER_A with no digits -> state stays 0; then 7,ENTER,ENTER -> state=1, operand_b=0, second ENTER ignored.
REQ-033 The bench SHALL cover: 5,ENTER,6,CLEAR -> state=0, all operands and result 0; then 8,ENTER,1,ENTER -> result=9.
REQ-034 The bench SHALL cover: in SHOW with result=357, key 4 -> state=0, operand_a=4, operand_b=0, digit_count=1, no result_valid.
REQ-035 The bench SHALL cover: rst_n pulsed low asynchronously between clock edges while in ENTER_B with operand_b=34 -> all outputs 0 immediately, state=0, and no result_valid afterwards.
